// File: rtl/vidscanout_pkg.sv
// vid_pkg: shared definitions for the video path.
//   - default 640x480@60 timing constants and the Game Boy source size
//   - rgb444_t pixel type and the stage-1 flag bundle
//   - vram_addr(): packs {y, x} into a VRAM address (also used by the sampler)
//   - CNT_W: width of the raster counters (covers totals up to 2047)
package vid_pkg;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;

    localparam int unsigned DEF_SRC_W = 160;
    localparam int unsigned DEF_SRC_H = 144;

    localparam int unsigned CNT_W = 11;

    typedef logic [11:0] rgb444_t;

    // Raster flags carried from the counter stage to the output stage.
    typedef struct packed {
        logic visible;
        logic window;
        logic hsync;
        logic vsync;
    } vid_flags_t;

    function automatic logic [15:0] vram_addr(input logic [7:0] y, input logic [7:0] x);
        return {y, x};
    endfunction

endpackage

// File: rtl/vidscanout_if.sv
// vidscanout_if: VRAM read-port bundle between the scanout and the frame VRAM.
//   vramclk   read clock (the pixel clock)
//   vramaddr  [15:8] source y, [7:0] source x
//   vramre    read enable
//   vramdata  2-bit shade, valid one clock after the address
// Modports: master = scanout side, slave = memory side.
interface vidscanout_if;

    logic        vramclk;
    logic [15:0] vramaddr;
    logic        vramre;
    logic [1:0]  vramdata;

    modport master (
        output vramclk,
        output vramaddr,
        output vramre,
        input  vramdata
    );

    modport slave (
        input  vramclk,
        input  vramaddr,
        input  vramre,
        output vramdata
    );

endinterface

// File: rtl/vidscanout_timing.sv
// vid_timing: raster counter for the scanout.
//   vid_clk, rst_n         pixel clock, asynchronous active-low reset
//   hcnt, vcnt             current raster position
//   hcnt_nxt, vcnt_nxt     position after the coming clock edge
//   hsync_raw, vsync_raw   active-low sync for the current position
//   visible                current position is inside the active area
//   frame_start            one-clock pulse while the position is (0,0)
// All flags are registered from the next position so they line up with
// hcnt/vcnt. After reset the counter holds at (0,0) for one edge so that
// frame (0,0) is presented with frame_start high.
module vid_timing
    import vid_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP
) (
    input  logic             vid_clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] hcnt,
    output logic [CNT_W-1:0] vcnt,
    output logic [CNT_W-1:0] hcnt_nxt,
    output logic [CNT_W-1:0] vcnt_nxt,
    output logic             hsync_raw,
    output logic             vsync_raw,
    output logic             visible,
    output logic             frame_start
);

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic run;

    always_comb begin
        hcnt_nxt = hcnt;
        vcnt_nxt = vcnt;
        if (run) begin
            if (hcnt == H_LAST) begin
                hcnt_nxt = '0;
                vcnt_nxt = (vcnt == V_LAST) ? '0 : vcnt + CNT_ONE;
            end else begin
                hcnt_nxt = hcnt + CNT_ONE;
            end
        end
    end

    always_ff @(posedge vid_clk or negedge rst_n) begin
        if (!rst_n) begin
            run         <= 1'b0;
            hcnt        <= '0;
            vcnt        <= '0;
            hsync_raw   <= 1'b1;
            vsync_raw   <= 1'b1;
            visible     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            run         <= 1'b1;
            hcnt        <= hcnt_nxt;
            vcnt        <= vcnt_nxt;
            hsync_raw   <= !((hcnt_nxt >= HS_START) && (hcnt_nxt < HS_END));
            vsync_raw   <= !((vcnt_nxt >= VS_START) && (vcnt_nxt < VS_END));
            visible     <= (hcnt_nxt < H_ACT) && (vcnt_nxt < V_ACT);
            frame_start <= (hcnt_nxt == '0) && (vcnt_nxt == '0);
        end
    end

endmodule

// File: rtl/vidscanout.sv
// vidscanout: display-side VRAM reader. Generates VGA-style timing, fetches
// 2-bit shades at {y, x}, replicates each source pixel SCALE times, centres
// the image in a border and maps shades to RGB444 via a per-frame palette.
// Ports:
//   vid_clk, rst_n   pixel clock, asynchronous active-low reset
//   vram             VRAM read port (vidscanout_if.master)
//   palette          four RGB444 entries, shade n at [12n+11:12n]
//   border           RGB444 colour outside the image window
//   hsync, vsync     active-low sync
//   de               visible-area strobe
//   rgb              RGB444 pixel (0 when not visible)
//   frame_start      one-clock pulse at raster (0,0), counter-aligned
// rgb/de/hsync/vsync lag the raster position by two clocks.
// Build option: VIDSCANOUT_SCANLINE_EN halves every channel on the last
// replicated line of each source row (image pixels only).
module vidscanout
    import vid_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP,
    parameter int unsigned SRC_W    = DEF_SRC_W,
    parameter int unsigned SRC_H    = DEF_SRC_H,
    parameter int unsigned SCALE    = 3,
    parameter int unsigned X_OFF    = (H_ACTIVE - SRC_W * SCALE) / 2,
    parameter int unsigned Y_OFF    = (V_ACTIVE - SRC_H * SCALE) / 2
) (
    input  logic                vid_clk,
    input  logic                rst_n,
    vidscanout_if.master        vram,
    input  logic [47:0]         palette,
    input  logic [11:0]         border,
    output logic                hsync,
    output logic                vsync,
    output logic                de,
    output logic [11:0]         rgb,
    output logic                frame_start
);

    localparam logic [CNT_W-1:0] X_START  = CNT_W'(X_OFF);
    localparam logic [CNT_W-1:0] X_END    = CNT_W'(X_OFF + SRC_W * SCALE);
    localparam logic [CNT_W-1:0] Y_START  = CNT_W'(Y_OFF);
    localparam logic [CNT_W-1:0] Y_END    = CNT_W'(Y_OFF + SRC_H * SCALE);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [1:0]       SUB_LAST = 2'(SCALE - 1);

    logic [CNT_W-1:0] hcnt, vcnt, hcnt_nxt, vcnt_nxt;
    logic             hsync_raw, vsync_raw, visible;

    vid_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .vid_clk     (vid_clk),
        .rst_n       (rst_n),
        .hcnt        (hcnt),
        .vcnt        (vcnt),
        .hcnt_nxt    (hcnt_nxt),
        .vcnt_nxt    (vcnt_nxt),
        .hsync_raw   (hsync_raw),
        .vsync_raw   (vsync_raw),
        .visible     (visible),
        .frame_start (frame_start)
    );

    assign vram.vramclk = vid_clk;

    // ---------------- stage 0: source coordinates and VRAM request ----------
    logic [1:0] xsub, xsub_n, ysub, ysub_n;
    logic [7:0] xsrc, xsrc_n, ysrc, ysrc_n;
    logic       win_n;

    // Sub-counters track the current raster position; their next values feed
    // the registered address so vramaddr lines up with hcnt/vcnt.
    always_comb begin
        xsub_n = xsub;
        xsrc_n = xsrc;
        ysub_n = ysub;
        ysrc_n = ysrc;

        // hcnt_nxt == X_OFF covers both "hcnt = X_OFF-1" and the X_OFF=0 line start.
        if (hcnt_nxt == X_START) begin
            xsub_n = '0;
            xsrc_n = '0;
        end else if (vram.vramre) begin
            if (xsub == SUB_LAST) begin
                xsub_n = '0;
                xsrc_n = xsrc + 8'd1;
            end else begin
                xsub_n = xsub + 2'd1;
            end
        end

        if (hcnt == H_LAST) begin
            if (vcnt_nxt == '0) begin
                ysub_n = '0;
                ysrc_n = '0;
            end else if ((vcnt >= Y_START) && (vcnt < Y_END)) begin
                if (ysub == SUB_LAST) begin
                    ysub_n = '0;
                    ysrc_n = ysrc + 8'd1;
                end else begin
                    ysub_n = ysub + 2'd1;
                end
            end
        end

        win_n = (hcnt_nxt >= X_START) && (hcnt_nxt < X_END) &&
                (vcnt_nxt >= Y_START) && (vcnt_nxt < Y_END);
    end

    always_ff @(posedge vid_clk or negedge rst_n) begin
        if (!rst_n) begin
            xsub          <= '0;
            xsrc          <= '0;
            ysub          <= '0;
            ysrc          <= '0;
            vram.vramre   <= 1'b0;
            vram.vramaddr <= '0;
        end else begin
            xsub        <= xsub_n;
            xsrc        <= xsrc_n;
            ysub        <= ysub_n;
            ysrc        <= ysrc_n;
            vram.vramre <= win_n;
            if (win_n) begin
                vram.vramaddr <= vram_addr(ysrc_n, xsrc_n);
            end
        end
    end

    // ---------------- per-frame palette / border latch ----------------------
    rgb444_t pal_q [4];
    rgb444_t border_q;

    always_ff @(posedge vid_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 4; i++) begin
                pal_q[i] <= '0;
            end
            border_q <= '0;
        end else if (frame_start) begin
            for (int unsigned i = 0; i < 4; i++) begin
                pal_q[i] <= palette[12*i +: 12];
            end
            border_q <= border;
        end
    end

    // ---------------- stage 1: flags wait for vramdata ----------------------
    vid_flags_t s1;

    always_ff @(posedge vid_clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '{visible: 1'b0, window: 1'b0, hsync: 1'b1, vsync: 1'b1};
        end else begin
            s1 <= '{visible: visible, window: vram.vramre, hsync: hsync_raw, vsync: vsync_raw};
        end
    end

`ifdef VIDSCANOUT_SCANLINE_EN
    logic scan1;

    always_ff @(posedge vid_clk or negedge rst_n) begin
        if (!rst_n) begin
            scan1 <= 1'b0;
        end else begin
            scan1 <= (ysub == SUB_LAST);
        end
    end
`endif

    // ---------------- stage 2: colour lookup onto the outputs ---------------
    rgb444_t rgb_n;

    always_comb begin
        rgb_n = '0;
        if (s1.visible) begin
            if (s1.window) begin
                rgb_n = pal_q[vram.vramdata];
`ifdef VIDSCANOUT_SCANLINE_EN
                if (scan1) begin
                    rgb_n = {1'b0, rgb_n[11:9], 1'b0, rgb_n[7:5], 1'b0, rgb_n[3:1]};
                end
`endif
            end else begin
                rgb_n = border_q;
            end
        end
    end

    always_ff @(posedge vid_clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb   <= '0;
            de    <= 1'b0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else begin
            rgb   <= rgb_n;
            de    <= s1.visible;
            hsync <= s1.hsync;
            vsync <= s1.vsync;
        end
    end

endmodule

// File: tb/tb_vidscanout.sv
// tb_vidscanout: self-checking bench for vidscanout on a reduced raster
// (54 x 37 clocks, 10x8 source at SCALE 3) so several frames fit in a short run.
// Derived geometry: X_OFF = (40-30)/2 = 5, Y_OFF = (30-24)/2 = 3,
// hsync low for h 44..49, vsync low for lines 32..33, last source pixel
// (x=9, y=7) fetched at h=34, line 26 -> vramaddr 0x0709.
// A generator follows the raster, checks the counter-aligned outputs and
// queues the expected video word; a monitor pops it two clocks later.
module tb_vidscanout;

    localparam int unsigned HA = 40, HF = 4, HS = 6, HB = 4;
    localparam int unsigned VA = 30, VF = 2, VS = 2, VB = 3;
    localparam int unsigned SW = 10, SH = 8, SC = 3;
    localparam int unsigned HT = 54, VT = 37;
    localparam int unsigned XO = 5, YO = 3;
    localparam int unsigned FRAME = HT * VT;

    logic        vid_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic [47:0] palette;
    logic [11:0] border;
    logic        hsync, vsync, de, frame_start;
    logic [11:0] rgb;

    vidscanout_if vram ();

    vidscanout #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .SRC_W    (SW), .SRC_H (SH), .SCALE (SC)
    ) dut (
        .vid_clk     (vid_clk),
        .rst_n       (rst_n),
        .vram        (vram),
        .palette     (palette),
        .border      (border),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .rgb         (rgb),
        .frame_start (frame_start)
    );

    always #5 vid_clk = ~vid_clk;

    // VRAM model: shade = x[1:0], one clock of read latency.
    initial vram.vramdata = 2'd0;
    always @(posedge vram.vramclk) begin
        if (vram.vramre) vram.vramdata <= vram.vramaddr[1:0];
    end

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc    = 0;
    always @(posedge vid_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic in_win(input int unsigned h, input int unsigned v);
        return (h >= XO) && (h < XO + SW * SC) && (v >= YO) && (v < YO + SH * SC);
    endfunction

    function automatic logic [14:0] exp_out(input int unsigned h, input int unsigned v,
                                            input logic [47:0] pal, input logic [11:0] bord);
        logic        vis, hs, vs;
        logic [11:0] c;
        int unsigned shade;
        vis = (h < HA) && (v < VA);
        hs  = !((h >= HA + HF) && (h < HA + HF + HS));
        vs  = !((v >= VA + VF) && (v < VA + VF + VS));
        c   = 12'h000;
        if (vis) begin
            if (in_win(h, v)) begin
                shade = ((h - XO) / SC) % 4;
                c = pal[12*shade +: 12];
`ifdef VIDSCANOUT_SCANLINE_EN
                if ((v - YO) % SC == SC - 1) c = (c >> 1) & 12'h777;
`endif
            end else begin
                c = bord;
            end
        end
        return {vis, hs, vs, c};
    endfunction

    typedef struct {
        int unsigned due;
        int unsigned h;
        int unsigned v;
        logic [14:0] exp;
    } ent_t;

    ent_t        q[$];
    logic        armed    = 1'b0;
    logic        tracking = 1'b0;
    int unsigned rh = 0, rv = 0, frames = 0;
    logic [47:0] pal_f;
    logic [11:0] bord_f;
    logic [15:0] last_addr = 16'h0000;

    // Generator: follows the raster from the first observed frame_start.
    always @(negedge vid_clk) begin
        ent_t e;
        logic win;
        if (rst_n && armed) begin
            if (!tracking && frame_start) begin
                tracking = 1'b1;
                rh = 0;
                rv = 0;
            end
            if (tracking) begin
                chk($sformatf("frame_start h%0d v%0d", rh, rv), frame_start, (rh == 0) && (rv == 0));
                if (rh == 0 && rv == 0) begin
                    pal_f  = palette;
                    bord_f = border;
                    frames++;
                end
                win = in_win(rh, rv);
                if (win) last_addr = {8'((rv - YO) / SC), 8'((rh - XO) / SC)};
                chk($sformatf("vramre h%0d v%0d", rh, rv), vram.vramre, win);
                chk($sformatf("vramaddr h%0d v%0d", rh, rv), vram.vramaddr, last_addr);
                if (rh == 34 && rv == 26) chk("last_src_addr", vram.vramaddr, 16'h0709);
                e.due = cyc + 2;
                e.h   = rh;
                e.v   = rv;
                e.exp = exp_out(rh, rv, pal_f, bord_f);
                q.push_back(e);
                if (rh == HT - 1) begin
                    rh = 0;
                    rv = (rv == VT - 1) ? 0 : rv + 1;
                end else begin
                    rh = rh + 1;
                end
            end
        end
    end

    // Monitor: compares {de, hsync, vsync, rgb} when the queued word falls due.
    always @(negedge vid_clk) begin
        ent_t e;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk($sformatf("video h%0d v%0d {de,hs,vs,rgb}", e.h, e.v), {de, hsync, vsync, rgb}, e.exp);
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_hsync"}, hsync, 1'b1);
        chk({tag, "_vsync"}, vsync, 1'b1);
        chk({tag, "_de"}, de, 1'b0);
        chk({tag, "_rgb"}, rgb, 12'h000);
        chk({tag, "_vramre"}, vram.vramre, 1'b0);
        chk({tag, "_vramaddr"}, vram.vramaddr, 16'h0000);
        chk({tag, "_frame_start"}, frame_start, 1'b0);
    endtask

    task automatic wait_pos(input int unsigned v, input int unsigned h, input int unsigned budget,
                            input string tag);
        int unsigned n = 0;
        while (!(tracking && rv == v && rh == h) && n < budget) begin
            @(negedge vid_clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL %s: position v%0d h%0d not reached in %0d cycles", tag, v, h, budget);
        end
    endtask

    task automatic wait_frames(input int unsigned target, input int unsigned budget, input string tag);
        int unsigned n = 0;
        while (frames < target && n < budget) begin
            @(negedge vid_clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL %s: frame count %0d, required %0d", tag, frames, target);
        end
    endtask

    initial begin
        int unsigned f0;
        palette = {12'hFFF, 12'hAAA, 12'h555, 12'h000};
        border  = 12'h123;
        repeat (3) @(negedge vid_clk);
        chk_reset("por");

        rst_n = 1'b1;
        armed = 1'b1;
        wait_frames(1, 10, "sync_after_por");

        // Mid-frame palette/border change must wait for the next frame_start.
        wait_pos(15, 0, 2 * FRAME, "palette_change_pos");
        palette = {12'h0F0, 12'hF00, 12'h00F, 12'h888};
        border  = 12'h456;

        // Asynchronous reset in the middle of frame 2.
        wait_pos(10, 20, 2 * FRAME, "reset_pos");
        #3;
        rst_n    = 1'b0;
        tracking = 1'b0;
        armed    = 1'b0;
        q.delete();
        last_addr = 16'h0000;
        #1;
        chk_reset("async_rst");
        repeat (5) @(negedge vid_clk);
        chk_reset("held_rst");
        rst_n = 1'b1;
        armed = 1'b1;
        @(negedge vid_clk);
        chk("fs_after_reset", frame_start, 1'b1);

        f0 = frames;
        wait_frames(f0 + 2, 2 * FRAME + 20, "run_after_reset");
        repeat (4) @(negedge vid_clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
